// File: rtl/hazard_sequencer.sv
// Hazard resolution for the 5-stage RV32I pipeline: EX forwarding, load-use stall, branch flush,
// data-memory wait/timeout handling and saturating stall/flush event counters.
module hazard_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_br_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             dmem_valid,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_wb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam int              WC_W      = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  logic [1:0]      state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            memfreeze;
  logic            loaduse;

  // MEM result is younger than WB, so it wins; x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       m_we, input logic [4:0] m_rd,
                                         input logic       w_we, input logic [4:0] w_rd);
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))      return 2'b01;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) return 2'b10;
    else                                             return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign fwd_a = fwd_sel(ex_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
  assign fwd_b = fwd_sel(ex_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd);

  assign memfreeze = (state != ST_ERR) && mem_access && !dmem_ack;
  assign loaduse   = ex_load && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    dmem_valid = 1'b0;
    mem_err    = 1'b0;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    flush_wb   = 1'b0;
    if (state == ST_ERR) begin
      mem_err   = 1'b1;
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else begin
      dmem_valid = (state == ST_WAIT) || mem_access;
      // A taken branch held in EX during a freeze flushes on the release (ack) cycle.
      if (memfreeze) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        flush_wb  = 1'b1;
      end else if (ex_br_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (loaduse) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_RUN: begin
        if (mem_access && !dmem_ack) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = WC_W'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WC_W'(1);
          if (wait_cnt == WAIT_LAST) state_nxt = ST_ERR;
        end
      end
      ST_ERR: begin
        state_nxt = ST_ERR;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (stall_if) stall_cnt <= sat_inc(stall_cnt);
      if (flush_id) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: vector table, hand-written multi-cycle sequences and random
// stimulus against a behavioural model; a second instance with 4-bit counters shows saturation.
module tb_hazard_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_load, ex_br_taken, mem_regwrite, wb_regwrite;
  logic       mem_access, dmem_ack;

  logic        dmem_valid, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, mem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        dmem_valid2, stall_if2, stall_id2, stall_ex2, stall_mem2, flush_id2, flush_ex2, flush_wb2, mem_err2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic [3:0]  stall_cnt2, flush_cnt2;

  hazard_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_load(ex_load),
    .ex_br_taken(ex_br_taken), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .mem_access(mem_access), .dmem_ack(dmem_ack), .dmem_valid(dmem_valid),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_wb(flush_wb), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  hazard_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_load(ex_load),
    .ex_br_taken(ex_br_taken), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .mem_access(mem_access), .dmem_ack(dmem_ack), .dmem_valid(dmem_valid2),
    .stall_if(stall_if2), .stall_id(stall_id2), .stall_ex(stall_ex2), .stall_mem(stall_mem2),
    .flush_id(flush_id2), .flush_ex(flush_ex2), .flush_wb(flush_wb2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .mem_err(mem_err2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_load, ex_br_taken;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic [4:0] wb_rd;
    logic       wb_regwrite, mem_access, dmem_ack;
  } in_t;

  typedef struct {
    in_t         in;
    logic [11:0] exp;
  } vec_t;

  // {dmem_valid, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, fwd_a, fwd_b}
  logic [11:0] outv, outv2;
  assign outv  = {dmem_valid, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, fwd_a, fwd_b};
  assign outv2 = {dmem_valid2, stall_if2, stall_id2, stall_ex2, stall_mem2, flush_id2, flush_ex2, flush_wb2, fwd_a2, fwd_b2};

  int checks = 0;
  int errors = 0;
  logic [11:0] obs;

  // Behavioural model: a pending access, the number of cycles it has gone unanswered, a sticky error.
  bit m_pend, m_err;
  int m_n, m_s, m_f;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] model_fwd(input in_t v, input logic [4:0] rs);
    if (v.mem_regwrite && v.mem_rd != 0 && v.mem_rd == rs) return 2'b01;
    if (v.wb_regwrite && v.wb_rd != 0 && v.wb_rd == rs)    return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [11:0] model_out(input in_t v);
    logic [1:0] fa, fb;
    logic       dv, frz, lu;
    fa = model_fwd(v, v.ex_rs1);
    fb = model_fwd(v, v.ex_rs2);
    if (m_err) return {1'b0, 4'b1111, 3'b000, fa, fb};
    dv  = m_pend || v.mem_access;
    frz = v.mem_access && !v.dmem_ack;
    lu  = v.ex_load && v.ex_rd != 0 &&
          ((v.id_use_rs1 && v.id_rs1 == v.ex_rd) || (v.id_use_rs2 && v.id_rs2 == v.ex_rd));
    if (frz)              return {dv, 4'b1111, 3'b001, fa, fb};
    if (v.ex_br_taken)    return {dv, 4'b0000, 3'b110, fa, fb};
    if (lu)               return {dv, 4'b1100, 3'b010, fa, fb};
    return {dv, 4'b0000, 3'b000, fa, fb};
  endfunction

  task automatic model_step(input in_t v, input logic [11:0] e);
    if (e[10]) m_s++;
    if (e[6])  m_f++;
    if (!m_err) begin
      if (!m_pend) begin
        if (v.mem_access && !v.dmem_ack) begin m_pend = 1; m_n = 1; end
      end else if (v.dmem_ack) begin
        m_pend = 0; m_n = 0;
      end else if (m_n + 1 >= TO) begin
        m_err = 1;
      end else begin
        m_n++;
      end
    end
  endtask

  function automatic int sat(input int x, input int maxv);
    return (x > maxv) ? maxv : x;
  endfunction

  task automatic drive(input in_t v);
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_use_rs1 = v.id_use_rs1; id_use_rs2 = v.id_use_rs2;
    ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd; ex_load = v.ex_load;
    ex_br_taken = v.ex_br_taken; mem_rd = v.mem_rd; mem_regwrite = v.mem_regwrite;
    wb_rd = v.wb_rd; wb_regwrite = v.wb_regwrite; mem_access = v.mem_access; dmem_ack = v.dmem_ack;
  endtask

  // Called at posedge+1; checks at the following negedge, model advances on the posedge after.
  task automatic cycle(input in_t v, input string nm);
    logic [11:0] e;
    drive(v);
    @(negedge clk);
    e   = model_out(v);
    obs = outv;
    chk({nm, "_out"}, 32'(outv), 32'(e));
    chk({nm, "_out4"}, 32'(outv2), 32'(e));
    chk({nm, "_err"}, 32'(mem_err), 32'(m_err));
    chk({nm, "_scnt"}, 32'(stall_cnt), 32'(sat(m_s, 65535)));
    chk({nm, "_fcnt"}, 32'(flush_cnt), 32'(sat(m_f, 65535)));
    chk({nm, "_scnt4"}, 32'(stall_cnt2), 32'(sat(m_s, 15)));
    chk({nm, "_fcnt4"}, 32'(flush_cnt2), 32'(sat(m_f, 15)));
    @(posedge clk);
    model_step(v, e);
    #1;
  endtask

  task automatic do_reset(input string nm);
    drive('0);
    rst_n = 1'b0;
    m_pend = 0; m_err = 0; m_n = 0; m_s = 0; m_f = 0;
    #1;
    chk({nm, "_out"}, 32'(outv), 32'h0);
    chk({nm, "_err"}, 32'(mem_err), 32'h0);
    chk({nm, "_scnt"}, 32'(stall_cnt), 32'h0);
    chk({nm, "_fcnt"}, 32'(flush_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  task automatic add(input in_t v, input logic [11:0] e);
    vec_t t;
    t.in  = v;
    t.exp = e;
    tbl.push_back(t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t v;
    int  s0, f0, dvc, stc;

    v = '0; add(v, 12'h000);
    v = '0; v.mem_regwrite = 1; v.mem_rd = 5; v.wb_regwrite = 1; v.wb_rd = 5; v.ex_rs1 = 5; add(v, 12'h004);
    v = '0; v.mem_regwrite = 1; v.mem_rd = 4; v.wb_regwrite = 1; v.wb_rd = 3; v.ex_rs2 = 3; add(v, 12'h002);
    v = '0; v.mem_regwrite = 1; v.wb_regwrite = 1; add(v, 12'h000);
    v = '0; v.mem_rd = 6; v.wb_regwrite = 1; v.wb_rd = 6; v.ex_rs1 = 6; v.ex_rs2 = 6; add(v, 12'h00A);
    v = '0; v.ex_load = 1; v.ex_rd = 7; v.id_rs2 = 7; v.id_use_rs2 = 1; add(v, 12'h620);
    v = '0; v.ex_load = 1; v.ex_rd = 7; v.id_rs2 = 7; v.id_use_rs2 = 1; v.ex_br_taken = 1; add(v, 12'h060);
    v = '0; v.ex_load = 1; v.id_use_rs1 = 1; add(v, 12'h000);
    v = '0; v.ex_load = 1; v.ex_rd = 7; v.id_rs2 = 7; add(v, 12'h000);
    v = '0; v.ex_load = 1; v.ex_rd = 9; v.id_rs1 = 9; v.id_use_rs1 = 1; add(v, 12'h620);
    v = '0; v.mem_access = 1; v.dmem_ack = 1; add(v, 12'h800);
    v = '0; v.mem_access = 1; v.dmem_ack = 1; v.ex_load = 1; v.ex_rd = 2; v.id_rs1 = 2; v.id_use_rs1 = 1;
    add(v, 12'hE20);

    do_reset("reset0");

    foreach (tbl[i]) begin
      cycle(tbl[i].in, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl", i), 32'(obs), 32'(tbl[i].exp));
    end

    // Three-cycle memory wait, released on the ack cycle.
    dvc = 0; stc = 0;
    v = '0; v.mem_access = 1;
    for (int i = 0; i < 4; i++) begin
      v.dmem_ack = (i == 3);
      cycle(v, $sformatf("t3_%0d", i));
      dvc += int'(obs[11]);
      stc += int'(obs[10] & obs[4]);
    end
    chk("t3_dv_cycles", 32'(dvc), 32'd4);
    chk("t3_stall_cycles", 32'(stc), 32'd3);
    cycle('0, "t3_idle");
    chk("t3_idle_out", 32'(obs), 32'h0);

    // Branch held during a two-cycle freeze flushes on the ack cycle.
    f0 = int'(flush_cnt);
    v = '0; v.mem_access = 1; v.ex_br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      v.dmem_ack = (i == 2);
      cycle(v, $sformatf("t5_%0d", i));
      chk($sformatf("t5_%0d_tbl", i), 32'(obs), (i == 2) ? 32'h860 : 32'hF90);
    end
    chk("t5_fcnt", 32'(flush_cnt), 32'(f0 + 1));

    // Reset while waiting with mem_access dropped: dmem_valid falls without a clock edge.
    v = '0; v.mem_access = 1;
    cycle(v, "t6w_a");
    cycle('0, "t6w_b");
    chk("t6w_wait_dv", 32'(obs[11]), 32'h1);
    do_reset("t6w_rst");

    // Timeout: sixteen frozen cycles, then sticky ERROR.
    s0 = int'(stall_cnt);
    v = '0; v.mem_access = 1;
    for (int i = 0; i < TO; i++) cycle(v, $sformatf("t4_%0d", i));
    chk("t4_scnt16", 32'(stall_cnt), 32'(s0 + TO));
    cycle(v, "t4_err0");
    chk("t4_err0_tbl", 32'(obs), 32'h780);
    chk("t4_mem_err", 32'(mem_err), 32'h1);
    v.dmem_ack = 1;
    cycle(v, "t4_err1");
    cycle('0, "t4_err2");
    chk("t4_sticky", 32'(mem_err), 32'h1);
    chk("t4_err2_tbl", 32'(obs), 32'h780);
    do_reset("t6e_rst");

    // Twenty load-use stalls: the 4-bit counter pins at 15.
    v = '0; v.ex_load = 1; v.ex_rd = 3; v.id_rs1 = 3; v.id_use_rs1 = 1;
    for (int i = 0; i < 20; i++) cycle(v, $sformatf("sat_%0d", i));
    chk("sat_cnt4", 32'(stall_cnt2), 32'd15);
    chk("sat_cnt16", 32'(stall_cnt), 32'd20);
    do_reset("reset1");

    for (int i = 0; i < 600; i++) begin
      v.id_rs1 = 5'($urandom_range(0, 3));   v.id_rs2 = 5'($urandom_range(0, 3));
      v.ex_rs1 = 5'($urandom_range(0, 3));   v.ex_rs2 = 5'($urandom_range(0, 3));
      v.ex_rd  = 5'($urandom_range(0, 3));   v.mem_rd = 5'($urandom_range(0, 3));
      v.wb_rd  = 5'($urandom_range(0, 3));
      v.id_use_rs1 = 1'($urandom); v.id_use_rs2 = 1'($urandom);
      v.ex_load = 1'($urandom); v.ex_br_taken = ($urandom_range(0, 3) == 0);
      v.mem_regwrite = 1'($urandom); v.wb_regwrite = 1'($urandom);
      v.mem_access = ($urandom_range(0, 2) == 0); v.dmem_ack = ($urandom_range(0, 3) != 0);
      if (i == 300) do_reset("rnd_rst");
      cycle(v, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
